// File: rtl/inpkt_pkg.sv
// ---------------------------------------------------------------------------
// inpkt_pkg
// Shared definitions for the input-packet parser: FSM state encoding, header
// word field positions, word/checksum widths, default framing parameters and
// a length-legality helper.
// ---------------------------------------------------------------------------
package inpkt_pkg;

  // Parser states, in the order a well-formed packet walks through them.
  typedef enum logic [2:0] {
    HDR0    = 3'd0,
    HDR1    = 3'd1,
    HDR2    = 3'd2,
    PAYLOAD = 3'd3,
    CKSUM   = 3'd4,
    HALT    = 3'd5
  } state_t;

  localparam int WORD_W  = 16;
  localparam int CKSUM_W = 16;

  // Header word 0 layout: {version, type}
  localparam int W0_VER_MSB  = 15;
  localparam int W0_VER_LSB  = 8;
  localparam int W0_TYPE_MSB = 7;
  localparam int W0_TYPE_LSB = 0;

  localparam logic [7:0] DEF_PKT_VERSION = 8'h02;
  localparam int         DEF_PKT_MAX_LEN = 4096;

  // A length word is legal when it is non-zero and no larger than max_len.
  function automatic logic len_legal(input logic [WORD_W-1:0] len, input int max_len);
    return (len != '0) && ({16'd0, len} <= 32'(max_len));
  endfunction

endpackage

// File: rtl/inpkt_parser.sv
// ---------------------------------------------------------------------------
// inpkt_parser
// Frames the 16-bit word stream popped from a first-word-fall-through input
// FIFO into packets (W0={ver,type}, W1=len, W2=id, payload[len], checksum)
// and forwards payload words to the core over valid/ready.
//
// Ports
//   CLK, RESET        clock; asynchronous active-high reset
//   din, empty        FIFO read data (valid while ~empty)
//   rd_en             FIFO pop, never asserted while empty
//   dout/_valid/_ready/_first/_last   payload output register handshake
//   pkt_type, pkt_id  header fields of the current packet
//   pkt_done, pkt_ok  one-cycle checksum verdict after the checksum pop
//   pkt_count         count of packets with a good checksum (wraps)
//   err_version, err_len, err_cksum   sticky error flags
// ---------------------------------------------------------------------------
module inpkt_parser
  import inpkt_pkg::*;
#(
  parameter logic [7:0] PKT_VERSION = DEF_PKT_VERSION,
  parameter int         PKT_MAX_LEN = DEF_PKT_MAX_LEN
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [WORD_W-1:0] din,
  input  logic              empty,
  output logic              rd_en,
  output logic [WORD_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_first,
  output logic              dout_last,
  output logic [7:0]        pkt_type,
  output logic [15:0]       pkt_id,
  output logic              pkt_done,
  output logic              pkt_ok,
  output logic [15:0]       pkt_count,
  output logic              err_version,
  output logic              err_len,
  output logic              err_cksum
);

  localparam int LEN_W = $clog2(PKT_MAX_LEN + 1);
  localparam logic [LEN_W-1:0] REM_ONE = LEN_W'(1);

  state_t              state_reg, state_next;
  logic [LEN_W-1:0]    rem_reg;
  logic [CKSUM_W-1:0]  sum_reg;
  logic                first_pend_reg;

  logic [WORD_W-1:0]   dout_reg;
  logic                dout_valid_reg, dout_first_reg, dout_last_reg;
  logic [7:0]          pkt_type_reg;
  logic [15:0]         pkt_id_reg, pkt_count_reg;
  logic                pkt_done_reg, pkt_ok_reg;
  logic                err_version_reg, err_len_reg, err_cksum_reg;

  logic                rd_en_next;
  logic                out_free;
  logic                ver_ok, len_ok, last_pop, ck_match;

  // The output register can take a new word when empty or being drained now.
  assign out_free = ~dout_valid_reg | dout_ready;
  assign ver_ok   = (din[W0_VER_MSB:W0_VER_LSB] == PKT_VERSION);
  assign len_ok   = len_legal(din, PKT_MAX_LEN);
  assign last_pop = (rem_reg == REM_ONE);
  assign ck_match = (din == sum_reg);

  // ---- FSM: state register ----
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_reg <= HDR0;
    else       state_reg <= state_next;
  end

  // ---- FSM: next-state logic; every transition requires a pop ----
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      HDR0:    if (rd_en_next) state_next = ver_ok ? HDR1 : HALT;
      HDR1:    if (rd_en_next) state_next = len_ok ? HDR2 : HALT;
      HDR2:    if (rd_en_next) state_next = PAYLOAD;
      PAYLOAD: if (rd_en_next && last_pop) state_next = CKSUM;
      CKSUM:   if (rd_en_next) state_next = HDR0;
      default: state_next = HALT;
    endcase
  end

  // ---- FSM: output logic (FIFO pop) ----
  // Payload and checksum pops wait for room in the output register; gating the
  // checksum pop this way also guarantees the last word is accepted first.
  always_comb begin
    rd_en_next = 1'b0;
    case (state_reg)
      HDR0, HDR1, HDR2: rd_en_next = ~empty;
      PAYLOAD, CKSUM:   rd_en_next = ~empty & out_free;
      default:          rd_en_next = 1'b0;
    endcase
  end

  assign rd_en = rd_en_next;

  // ---- Payload output register ----
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
      dout_first_reg <= 1'b0;
      dout_last_reg  <= 1'b0;
    end else if (rd_en_next && state_reg == PAYLOAD) begin
      dout_reg       <= din;
      dout_valid_reg <= 1'b1;
      dout_first_reg <= first_pend_reg;
      dout_last_reg  <= last_pop;
    end else if (dout_ready) begin
      dout_valid_reg <= 1'b0;
    end
  end

  // ---- Header capture, running sum, counters and error flags ----
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rem_reg         <= '0;
      sum_reg         <= '0;
      first_pend_reg  <= 1'b0;
      pkt_type_reg    <= '0;
      pkt_id_reg      <= '0;
      pkt_count_reg   <= '0;
      pkt_done_reg    <= 1'b0;
      pkt_ok_reg      <= 1'b0;
      err_version_reg <= 1'b0;
      err_len_reg     <= 1'b0;
      err_cksum_reg   <= 1'b0;
    end else begin
      pkt_done_reg <= 1'b0;
      pkt_ok_reg   <= 1'b0;
      if (rd_en_next) begin
        case (state_reg)
          HDR0: begin
            // Sum restarts with W0 itself.
            sum_reg <= din;
            if (ver_ok) pkt_type_reg <= din[W0_TYPE_MSB:W0_TYPE_LSB];
            else        err_version_reg <= 1'b1;
          end
          HDR1: begin
            sum_reg <= sum_reg + din;
            if (len_ok) rem_reg <= din[LEN_W-1:0];
            else        err_len_reg <= 1'b1;
          end
          HDR2: begin
            sum_reg        <= sum_reg + din;
            pkt_id_reg     <= din;
            first_pend_reg <= 1'b1;
          end
          PAYLOAD: begin
            sum_reg        <= sum_reg + din;
            rem_reg        <= rem_reg - REM_ONE;
            first_pend_reg <= 1'b0;
          end
          CKSUM: begin
            pkt_done_reg <= 1'b1;
            pkt_ok_reg   <= ck_match;
            if (ck_match) pkt_count_reg <= pkt_count_reg + 16'd1;
            else          err_cksum_reg <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign dout        = dout_reg;
  assign dout_valid  = dout_valid_reg;
  assign dout_first  = dout_first_reg;
  assign dout_last   = dout_last_reg;
  assign pkt_type    = pkt_type_reg;
  assign pkt_id      = pkt_id_reg;
  assign pkt_done    = pkt_done_reg;
  assign pkt_ok      = pkt_ok_reg;
  assign pkt_count   = pkt_count_reg;
  assign err_version = err_version_reg;
  assign err_len     = err_len_reg;
  assign err_cksum   = err_cksum_reg;

endmodule

// File: tb/tb_inpkt_parser.sv
// ---------------------------------------------------------------------------
// tb_inpkt_parser
// Scoreboard bench: packets are built from the framing rules and pushed both
// into a FIFO model and into expected-word / expected-verdict queues; a
// separate monitor compares whatever the parser presents.
// ---------------------------------------------------------------------------
module tb_inpkt_parser;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [15:0] din = 16'd0;
  logic        empty = 1'b1;
  logic        rd_en;
  logic [15:0] dout;
  logic        dout_valid;
  logic        dout_ready = 1'b1;
  logic        dout_first, dout_last;
  logic [7:0]  pkt_type;
  logic [15:0] pkt_id;
  logic        pkt_done, pkt_ok;
  logic [15:0] pkt_count;
  logic        err_version, err_len, err_cksum;

  inpkt_parser dut (
    .CLK(CLK), .RESET(RESET), .din(din), .empty(empty), .rd_en(rd_en),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_first(dout_first), .dout_last(dout_last),
    .pkt_type(pkt_type), .pkt_id(pkt_id), .pkt_done(pkt_done), .pkt_ok(pkt_ok),
    .pkt_count(pkt_count), .err_version(err_version), .err_len(err_len),
    .err_cksum(err_cksum)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [15:0] d; bit first; bit last; int pkt; } word_t;
  typedef struct { bit ok; logic [7:0] typ; logic [15:0] id; logic [15:0] cnt; int pkt; } pres_t;

  word_t       exp_words[$];
  pres_t       exp_pkts[$];
  logic [15:0] fifo_q[$];

  int          checks = 0;
  int          failures = 0;
  int          pkt_seq = 0;
  int          pop_cnt = 0;
  logic [15:0] model_count = 16'd0;
  bit          will_pop = 1'b0;
  bit          mon_en = 1'b0;
  bit          stall_en = 1'b0;
  bit          rand_ready = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Build one packet from the framing rules: checksum is the 16-bit wrapped
  // sum of W0, W1, W2 and all payload words.
  task automatic queue_pkt(input logic [15:0] w0, input int len, input logic [15:0] id,
                           input bit seq, input bit bad);
    logic [15:0] sum;
    logic [15:0] w;
    word_t e;
    pres_t p;
    sum = w0 + 16'(len) + id;
    fifo_q.push_back(w0);
    fifo_q.push_back(16'(len));
    fifo_q.push_back(id);
    for (int i = 0; i < len; i++) begin
      w = seq ? 16'(i + 1) : 16'($urandom);
      sum = sum + w;
      fifo_q.push_back(w);
      e.d = w; e.first = (i == 0); e.last = (i == len - 1); e.pkt = pkt_seq;
      exp_words.push_back(e);
    end
    fifo_q.push_back(bad ? sum + 16'd1 : sum);
    if (!bad) model_count = model_count + 16'd1;
    p.ok = !bad; p.typ = w0[7:0]; p.id = id; p.cnt = model_count; p.pkt = pkt_seq;
    exp_pkts.push_back(p);
    pkt_seq++;
  endtask

  // One clock of FIFO model + input drive; decisions are taken mid-cycle.
  task automatic tick();
    @(negedge CLK);
    if (will_pop) begin
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      pop_cnt++;
    end
    empty = (fifo_q.size() == 0) || (stall_en && ($urandom_range(3) == 0));
    din = (fifo_q.size() > 0) ? fifo_q[0] : 16'($urandom);
    dout_ready = rand_ready ? 1'($urandom_range(1)) : 1'b1;
    #1;
    chk("rd_en_while_empty", {63'd0, rd_en & empty}, 64'd0);
    will_pop = rd_en & ~empty;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    fifo_q.delete();
    exp_words.delete();
    exp_pkts.delete();
    will_pop = 1'b0;
    model_count = 16'd0;
    empty = 1'b1;
    #1;
    chk("reset_data", {32'd0, dout, pkt_id}, 64'd0);
    chk("reset_ctrl", {35'd0, dout_valid, dout_first, dout_last, pkt_done, pkt_ok,
                       err_version, err_len, err_cksum, rd_en, pkt_type, pkt_count}, 64'd0);
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    mon_en = 1'b1;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((fifo_q.size() > 0 || exp_words.size() > 0 || exp_pkts.size() > 0) && n < budget) begin
      tick();
      n++;
    end
    chk(name, 64'(fifo_q.size() + exp_words.size() + exp_pkts.size()), 64'd0);
    repeat (4) tick();
  endtask

  // ---- Monitor: compares presented outputs against the scoreboard ----
  bit          hold_v = 1'b0;
  logic [17:0] hold_w;
  always @(negedge CLK) begin
    word_t e;
    pres_t p;
    #2;
    if (!mon_en) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) chk("dout_stable", {45'd0, dout_valid, dout, dout_first, dout_last},
                      {45'd0, 1'b1, hold_w});
      if (dout_valid && dout_ready) begin
        chk("unexpected_dout", {63'd0, exp_words.size() == 0}, 64'd0);
        if (exp_words.size() > 0) begin
          e = exp_words.pop_front();
          chk("dout_word", {46'd0, dout, dout_first, dout_last}, {46'd0, e.d, e.first, e.last});
        end
      end
      hold_v = dout_valid && !dout_ready;
      hold_w = {dout, dout_first, dout_last};
      if (pkt_done) begin
        chk("unexpected_pkt_done", {63'd0, exp_pkts.size() == 0}, 64'd0);
        if (exp_pkts.size() > 0) begin
          p = exp_pkts.pop_front();
          chk("pkt_result", {23'd0, pkt_ok, pkt_type, pkt_id, pkt_count},
              {23'd0, p.ok, p.typ, p.id, p.cnt});
          if (exp_words.size() > 0)
            chk("done_before_last", {63'd0, exp_words[0].pkt <= p.pkt}, 64'd0);
        end
      end
    end
  end

  initial begin
    int base;
    int len;
    do_reset();

    // 1: nominal packet, sequential payload
    queue_pkt(16'h0211, 3, 16'hBEEF, 1'b1, 1'b0);
    drain("t1_drain", 100);
    chk("t1_count", 64'(pkt_count), 64'd1);
    chk("t1_errs", {61'd0, err_version, err_len, err_cksum}, 64'd0);

    // 2: bad checksum then good packet
    do_reset();
    queue_pkt(16'h0211, 3, 16'hBEEF, 1'b1, 1'b1);
    queue_pkt(16'h0211, 3, 16'hBEEF, 1'b1, 1'b0);
    drain("t2_drain", 100);
    chk("t2_err_cksum", {63'd0, err_cksum}, 64'd1);
    chk("t2_count", 64'(pkt_count), 64'd1);

    // 3: version mismatch halts popping
    do_reset();
    fifo_q = '{16'h0311, 16'd1, 16'h1234, 16'h0005, 16'h0006};
    base = pop_cnt;
    repeat (100) tick();
    chk("t3_pops", 64'(pop_cnt - base), 64'd1);
    chk("t3_flags", {61'd0, err_version, err_len, err_cksum}, 64'b100);
    do_reset();
    chk("t3_cleared", {63'd0, err_version}, 64'd0);

    // 4: illegal lengths halt; maximum length accepted
    fifo_q = '{16'h0205, 16'd0, 16'h1111, 16'h0001, 16'h0002};
    base = pop_cnt;
    repeat (30) tick();
    chk("t4_len0_pops", 64'(pop_cnt - base), 64'd2);
    chk("t4_len0_flags", {61'd0, err_version, err_len, err_cksum}, 64'b010);
    do_reset();
    fifo_q = '{16'h0205, 16'd4097, 16'h1111, 16'h0001, 16'h0002};
    base = pop_cnt;
    repeat (30) tick();
    chk("t4_lenbig_pops", 64'(pop_cnt - base), 64'd2);
    chk("t4_lenbig_flags", {61'd0, err_version, err_len, err_cksum}, 64'b010);
    do_reset();
    queue_pkt(16'h02AB, 4096, 16'h4096, 1'b0, 1'b0);
    drain("t4_max_drain", 6000);
    chk("t4_max_count", 64'(pkt_count), 64'd1);
    chk("t4_max_errs", {61'd0, err_version, err_len, err_cksum}, 64'd0);

    // 5: random traffic with back-pressure and FIFO stalls
    do_reset();
    stall_en = 1'b1;
    rand_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      len = $urandom_range(8, 1);
      queue_pkt({8'h02, 8'($urandom)}, len, 16'($urandom), 1'b0, $urandom_range(7) == 0);
    end
    drain("t5_drain", 20000);
    chk("t5_count", 64'(pkt_count), 64'(model_count));
    stall_en = 1'b0;
    rand_ready = 1'b0;

    // 6: reset in the middle of a payload, then a fresh packet
    do_reset();
    queue_pkt(16'h0233, 5, 16'h5555, 1'b1, 1'b0);
    base = pop_cnt;
    for (int n = 0; n < 50 && (pop_cnt - base) < 5; n++) tick();
    chk("t6_reached_payload", 64'(pop_cnt - base), 64'd5);
    do_reset();
    queue_pkt(16'h0244, 4, 16'h6666, 1'b0, 1'b0);
    drain("t6_drain", 100);
    chk("t6_count", 64'(pkt_count), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
